// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared widths, fetch FSM encoding and PC helpers for the fetch queue
// Ports: none (package only).
package inst_fetch_queue_pkg;
  localparam int WORD_W  = 32;
  localparam int INST_W  = 32;
  localparam int ENTRY_W = INST_W + WORD_W;
  // REQ: may issue, WAIT: one read outstanding, DROP: outstanding read must be discarded
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [WORD_W-1:0] pc_plus4;
  } fetch_entry_t;
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
    return a & ~32'd3;
  endfunction
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry FIFO with flush, occupancy count and combinational head read
// Ports: clk/rst (async active-low), flush clears pointers and count, push/push_data write,
//        pop removes head (ignored when empty), empty, count, head (holds last shown entry when empty).
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]  hold;
  logic          do_push, do_pop;
  assign empty   = count == '0;
  assign do_push = push && count != (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  // Once the queue drains the outputs keep showing the last entry that was at the head
  assign head    = empty ? hold : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (!empty) hold <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (do_pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
    end
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch stage issuing single-outstanding I-cache reads into a PC+4-tagged FIFO
// Ports: clk, rst (async active-low), icache_rd_en/icache_addr request, icache_data/icache_valid response,
//        redirect/redirect_addr flush and refetch, rd_en pop, empty/inst_out/pc_plus4_out head view.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              icache_rd_en,
  output logic [WORD_W-1:0] icache_addr,
  input  logic [INST_W-1:0] icache_data,
  input  logic              icache_valid,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_addr,
  input  logic              rd_en,
  output logic              empty,
  output logic [INST_W-1:0] inst_out,
  output logic [WORD_W-1:0] pc_plus4_out
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0]        state, state_next;
  logic [WORD_W-1:0] pc, req_addr;
  logic [AW:0]       count;
  logic              push;
  fetch_entry_t      head, push_entry;
  // Space is reserved when the request goes out, so a later push can never overflow
  assign icache_rd_en = rst && state == ST_REQ && count < (AW+1)'(DEPTH) && !redirect;
  assign icache_addr  = pc;
  assign push         = state == ST_WAIT && icache_valid && !redirect;
  assign push_entry   = '{inst: icache_data, pc_plus4: req_addr + PC_INC};
  assign inst_out     = head.inst;
  assign pc_plus4_out = head.pc_plus4;
  // A response arriving with or after a redirect always retires the outstanding read
  always_comb begin
    state_next = state == ST_REQ  ? (icache_rd_en ? ST_WAIT : ST_REQ) :
                 state == ST_WAIT ? (icache_valid ? ST_REQ : (redirect ? ST_DROP : ST_WAIT)) :
                 state == ST_DROP ? (icache_valid ? ST_REQ : ST_DROP) : ST_REQ;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_REQ;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= redirect ? word_align(redirect_addr) : icache_rd_en ? pc + PC_INC : pc;
      if (icache_rd_en) req_addr <= pc;
    end
  end
  ifq_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (rd_en && !redirect),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: randomized and directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
  logic        clk = 0;
  logic        rst, icache_rd_en, icache_valid, redirect, rd_en, empty;
  logic [31:0] icache_addr, icache_data, redirect_addr, inst_out, pc_plus4_out;
  int          n_chk = 0, n_pass = 0;
  int          m_mode, resp_cnt = 0, lat_lo = 1, lat_hi = 1, nreq = 0;
  logic [31:0] m_pc, m_req;
  logic [63:0] q[$];
  logic [63:0] last;
  bit          fixed_data = 1, force_v = 0, found;
  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .icache_rd_en(icache_rd_en), .icache_addr(icache_addr),
    .icache_data(icache_data), .icache_valid(icache_valid), .redirect(redirect),
    .redirect_addr(redirect_addr), .rd_en(rd_en), .empty(empty),
    .inst_out(inst_out), .pc_plus4_out(pc_plus4_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic model_reset();
    m_mode = 0;
    m_pc   = 32'h0;
    m_req  = 32'h0;
    q.delete();
    last   = 64'h0;
  endtask
  // m_mode: 0 idle, 1 read outstanding, 2 outstanding read to be thrown away
  task automatic step(input logic rn, input logic rd, input logic rdr, input logic [31:0] ra);
    logic exp_rd, v;
    logic [63:0] exp_head;
    @(negedge clk);
    rst = rn; rd_en = rd; redirect = rdr; redirect_addr = ra;
    v = force_v;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) v = 1;
    end
    icache_valid = v;
    icache_data  = fixed_data ? 32'h2008_0005 : $urandom;
    if (!rn) model_reset();
    #1;
    exp_rd   = rn && m_mode == 0 && q.size() < DEPTH && !rdr;
    exp_head = q.size() > 0 ? q[0] : last;
    check("rd_en", icache_rd_en, exp_rd);
    check("addr", icache_addr, m_pc);
    check("empty", empty, q.size() == 0);
    check("head", {inst_out, pc_plus4_out}, exp_head);
    if (icache_rd_en) nreq++;
    if (q.size() > 0) last = q[0];
    if (rn) begin
      if (rdr) begin
        q.delete();
        m_pc = ra & ~32'd3;
        if (m_mode == 1) m_mode = v ? 0 : 2;
        else if (m_mode == 2 && v) m_mode = 0;
      end else begin
        if (rd && q.size() > 0) void'(q.pop_front());
        if (m_mode == 1 && v) begin
          q.push_back({icache_data, m_req + 32'd4});
          m_mode = 0;
        end else if (m_mode == 2 && v) m_mode = 0;
        else if (exp_rd) begin
          m_req  = m_pc;
          m_pc   = m_pc + 32'd4;
          m_mode = 1;
        end
      end
    end
    if (exp_rd) resp_cnt = $urandom_range(lat_hi, lat_lo);
  endtask
  task automatic wait_req(input int budget);
    found = 0;
    for (int k = 0; k < budget && !found; k++) begin
      step(1, 0, 0, 0);
      found = icache_rd_en;
    end
    check("req_seen", found, 1);
  endtask
  initial begin
    rst = 0; rd_en = 0; redirect = 0; redirect_addr = 0; icache_valid = 0; icache_data = 0;
    model_reset();
    repeat (2) step(0, 0, 0, 0);
    nreq = 0;
    repeat (12) step(1, 0, 0, 0);
    check("fill_reqs", nreq, 4);
    nreq = 0;
    step(1, 1, 0, 0);
    repeat (6) step(1, 0, 0, 0);
    check("refill_reqs", nreq, 1);
    repeat (12) step(1, 1, 0, 0);
    lat_lo = 3; lat_hi = 3;
    wait_req(20);
    step(1, 0, 1, 32'h0040_0100);
    lat_lo = 1; lat_hi = 1;
    wait_req(10);
    check("redir_addr", icache_addr, 32'h0040_0100);
    repeat (2) step(1, 0, 0, 0);
    check("redir_pc4", pc_plus4_out, 32'h0040_0104);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1, 0, 0, 0);
      found = q.size() == 2;
    end
    check("two_queued", empty, 0);
    step(1, 1, 1, 32'h0000_1000);
    step(1, 0, 0, 0);
    check("flush_empty", empty, 1);
    check("flush_addr", icache_addr, 32'h0000_1000);
    step(1, 0, 1, 32'hFFFF_FFFC);
    repeat (3) step(1, 0, 0, 0);
    check("wrap_pc4", pc_plus4_out, 32'h0);
    check("wrap_addr", icache_addr, 32'h0);
    fixed_data = 0; lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 3000; i++)
      step(1, $urandom_range(0, 99) < (i < 1500 ? 25 : 60), $urandom_range(0, 99) < 5,
           $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom);
    lat_lo = 3; lat_hi = 3;
    step(1, 0, 1, 32'h0000_0200);
    wait_req(20);
    resp_cnt = 0; force_v = 1;
    step(0, 0, 0, 0);
    force_v = 0;
    step(0, 1, 0, 0);
    force_v = 1;
    step(1, 0, 0, 0);
    force_v = 0;
    check("rst_empty", empty, 1);
    check("rst_addr", icache_addr, 32'h0);
    lat_lo = 1; lat_hi = 2;
    repeat (10) step(1, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Fetch stage feeding the dispatch unit. Holds the PC, issues single-outstanding reads to the instruction cache, and buffers fetched instructions with their PC+4 in a small FIFO. Dispatch pops the FIFO. The jump/branch address logic consumes the head's pc_plus4. On a redirect from dispatch, the queue flushes and fetch restarts at the supplied target.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 32'h00000000, PC value after reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (asserted at 0)
icache_rd_en  output  1  read request to I-cache, one cycle per request
icache_addr  output  32  fetch address (current PC), word aligned
icache_data  input  32  instruction returned by I-cache
icache_valid  input  1  icache_data valid, >=1 cycle after icache_rd_en
redirect  input  1  dispatch: jump/branch taken, flush and refetch
redirect_addr  input  32  target from address logic (Jmp_branch_address)
rd_en  input  1  dispatch pops head entry
empty  output  1  FIFO has no entries
inst_out  output  32  head instruction
pc_plus4_out  output  32  head instruction address + 4

Behaviour:
- Reset (rst=0, async): PC=RESET_PC, count=0, read/write pointers=0, storage=0, state=REQ.
- Reset values: icache_rd_en=0, icache_addr=RESET_PC, empty=1, inst_out=0, pc_plus4_out=0.
- FSM states:
  - REQ: may issue a request.
  - WAIT: one request outstanding.
  - DROP: outstanding response must be discarded.
- icache_rd_en = (state==REQ) && (count<DEPTH) && !redirect, combinational. icache_addr = PC.
- REQ with icache_rd_en=1: next PC=PC+4, latch req_addr=PC, go to WAIT. Otherwise stay in REQ.
- WAIT with icache_valid=1 and no redirect: push {icache_data, req_addr+4}, return to REQ. A new request is issued no earlier than the next cycle.
- Peak throughput is one instruction per 2 cycles with 1-cycle cache latency.
- Space is reserved at request time (count<DEPTH checked in REQ), so a WAIT push never overflows. A push and a pop in the same cycle leave count unchanged.
- rd_en while empty=1: ignored, no pointer or count change.
- inst_out and pc_plus4_out show the head entry combinationally; they hold their last value when empty.
- Redirect, any state, highest priority:
  - count=0 and pointers cleared next edge.
  - Same-cycle rd_en and push are discarded.
  - PC=redirect_addr.
- Redirect state transitions:
  - From WAIT without icache_valid the same cycle: go to DROP.
  - From WAIT with icache_valid the same cycle: the data is dropped and the FSM goes to REQ.
  - From REQ or DROP: stay, with the rd_en suppression above.
- DROP: on icache_valid, discard data and go to REQ. A further redirect in DROP only updates PC.
- PC arithmetic is modulo 2^32; PC=32'hFFFFFFFC wraps to 0. redirect_addr[1:0] are ignored (forced to 00).
- Reset mid-WAIT or mid-DROP: state returns to REQ. A late icache_valid arriving in REQ is ignored.

Decomposition:
- Shared package: WORD_W=32, INST_W=32, fetch FSM state encoding (REQ, WAIT, DROP), PC increment constant 4.
- One natural sub-module, ifq_fifo: DEPTH-entry, 64-bit wide synchronous FIFO with flush, count, and combinational head read.
- FSM and PC stay in the top module.

Test Plan:
- Reset release, cache returns 0x20080005 one cycle after each request: icache_addr sequence 0x0, 0x4, 0x8. First entry inst_out=0x20080005, pc_plus4_out=0x4. empty falls 2 cycles after the first rd_en.
- No rd_en from dispatch, DEPTH=4: exactly 4 requests issued, then icache_rd_en stays 0. One pop re-enables exactly one request.
- Redirect to 0x00400100 while in WAIT, valid arrives 3 cycles later: the response is discarded, empty=1. The next icache_addr is 0x00400100, and that entry has pc_plus4_out=0x00400104.
- Redirect and rd_en asserted with 2 entries queued: count becomes 0 and empty=1 next cycle. No underflow, and the following fetch uses the target.
- PC=0xFFFFFFFC fetch: pc_plus4_out=0x00000000 and the next icache_addr is 0x0.
- rst pulled low while in WAIT, valid pulsed during and after reset: FIFO empty, icache_addr=RESET_PC, no entry pushed.
